// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : plot_arbiter
//  Description : Round-robin owner arbiter for the single vga_adapter pixel
//                write port. Each drawing engine requests ownership and
//                streams a burst of pixels; the winning pixel is registered
//                onto the VGA port. Burst length is capped so no engine can
//                monopolise the port.
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_arbiter #(
    parameter int N_REQ     = 4,
    parameter int COORD_W   = 8,
    parameter int COLOUR_W  = 3,
    parameter int MAX_BURST = 256
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          last,
    input  logic [N_REQ*COORD_W-1:0]  px_x,
    input  logic [N_REQ*COORD_W-1:0]  px_y,
    input  logic [N_REQ*COLOUR_W-1:0] px_colour,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [COORD_W-1:0]        vga_x,
    output logic [COORD_W-1:0]        vga_y,
    output logic [COLOUR_W-1:0]       vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic [2:0]                owner
);

    // Counter is wide enough to hold MAX_BURST itself, even when MAX_BURST=1.
    localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
    localparam logic [2:0]         c_TOP_IDX   = 3'(N_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [2:0]           r_ptr;
    logic [2:0]           r_owner;
    logic [c_CNT_W-1:0]   r_count;
    logic [N_REQ-1:0]     r_gnt;
    logic                 r_busy;
    logic                 r_plot;
    logic [COORD_W-1:0]   r_vga_x;
    logic [COORD_W-1:0]   r_vga_y;
    logic [COLOUR_W-1:0]  r_vga_colour;

    logic                 w_any_req;
    logic [2:0]           w_pick;
    logic [2:0]           w_pick_hi;
    logic [2:0]           w_pick_lo;
    logic                 w_found_hi;
    logic                 w_own_ack;
    logic                 w_sel_last;
    logic [COORD_W-1:0]   w_sel_x;
    logic [COORD_W-1:0]   w_sel_y;
    logic [COLOUR_W-1:0]  w_sel_colour;
    logic [2:0]           w_ptr_next;

    // Only the owner can ever be acknowledged since gnt is one-hot on it.
    assign ack       = r_gnt & req;
    assign w_own_ack = |ack;
    assign w_any_req = |req;

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign owner      = r_owner;
    assign vga_plot   = r_plot;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;

    assign w_ptr_next = (r_owner == c_TOP_IDX) ? 3'd0 : (r_owner + 3'd1);

    // Round-robin pick: lowest requester at/after the pointer, else lowest overall.
    always_comb begin
        w_pick_hi  = 3'd0;
        w_pick_lo  = 3'd0;
        w_found_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_pick_lo = 3'(i);
                if (3'(i) >= r_ptr) begin
                    w_pick_hi  = 3'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
    end

    // Select the current owner's pixel slice and last flag.
    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_sel_last   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == 3'(i)) begin
                w_sel_x      = px_x[i*COORD_W +: COORD_W];
                w_sel_y      = px_y[i*COORD_W +: COORD_W];
                w_sel_colour = px_colour[i*COLOUR_W +: COLOUR_W];
                w_sel_last   = last[i];
            end
        end
    end

    // Grant FSM, burst counter and registered VGA write port.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state      <= S_IDLE;
            r_ptr        <= 3'd0;
            r_owner      <= 3'd0;
            r_count      <= '0;
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_plot       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_plot <= 1'b0;
                    if (w_any_req) begin
                        r_gnt   <= N_REQ'(1) << w_pick;
                        r_owner <= w_pick;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_own_ack) begin
                        r_vga_x      <= w_sel_x;
                        r_vga_y      <= w_sel_y;
                        r_vga_colour <= w_sel_colour;
                        r_plot       <= 1'b1;
                        r_count      <= r_count + 1'b1;
                        // Last pixel and burst cap coinciding still release once.
                        if (w_sel_last || (r_count == c_LAST_BEAT)) begin
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                            r_ptr   <= w_ptr_next;
                        end
                    end else begin
                        // Owner withdrew its request: give the port up.
                        r_plot  <= 1'b0;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
Shares the single vga_adapter pixel-write port (x, y, colour, plot) between several drawing engines: screen clear, floor/ceiling border, obstacle renderer and bird sprite. Each engine requests ownership and streams pixels as a burst. The arbiter grants one owner at a time in round-robin order, caps burst length so no engine starves the others, and registers the winning pixel onto the VGA port.

Parameters:
N_REQ, 4, number of requesters (2..8)
COORD_W, 8, width of x and y coordinates
COLOUR_W, 3, colour width
MAX_BURST, 256, maximum pixels accepted per grant before forced release (>=1)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
resetn  in  1  asynchronous, active-high reset; asserted high clears all state immediately
req  in  N_REQ  per-requester request / pixel-valid
last  in  N_REQ  per-requester flag: the current pixel ends the burst
px_x  in  N_REQ*COORD_W  packed x; requester i occupies bits [i*COORD_W +: COORD_W]
px_y  in  N_REQ*COORD_W  packed y, same packing
px_colour  in  N_REQ*COLOUR_W  packed colour
gnt  out  N_REQ  registered one-hot grant
ack  out  N_REQ  combinational: gnt & req; pixel consumed this cycle
vga_x  out  COORD_W  registered x to vga_adapter
vga_y  out  COORD_W  registered y
vga_colour  out  COLOUR_W  registered colour
vga_plot  out  1  registered write strobe
busy  out  1  high while a grant is held
owner  out  3  index of the current or most recent owner

Behaviour:
- Reset values: gnt=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, owner=0. Round-robin pointer=0, burst count=0, state=IDLE.
- States: IDLE and OWN.
- IDLE: if any req is high, choose the first requester set at or after the pointer, wrapping modulo N_REQ. On the next edge: gnt one-hot for that requester, owner=index, state=OWN, count=0. With no req, remain in IDLE.
- OWN: ack[i]=gnt[i]&req[i]. Each acked cycle, on the next edge: vga_x/y/colour take the owner's slice and vga_plot=1. Cycles without ack give vga_plot=0. vga_x/y/colour hold their value when not plotting.
- Burst count increments on each ack.
- Release conditions, evaluated on the edge ending the cycle:
  - (a) ack with last[owner]=1;
  - (b) ack when count==MAX_BURST-1 (forced release);
  - (c) req[owner]=0 (pixel not taken).
- On release: gnt=0, state=IDLE, pointer=owner+1 mod N_REQ. There is always exactly one IDLE bubble cycle between grants.
- Latency: req rises in cycle t in IDLE -> gnt and first ack in t+1 -> vga_plot in t+2. Sustained throughput is 1 pixel/cycle within a burst.
- Forced release does not inform the requester. The requester keeps req high and re-competes; other requesters pending at that time win first.
- Requests from non-owners are ignored while in OWN, and ack is never set for a non-owner.
- Simultaneous last and forced release: single release; the pointer advances once.
- Owner drops req, then raises it in the same IDLE bubble: it re-competes normally from the advanced pointer.
- resetn asserted mid-burst: all outputs clear asynchronously, and the in-flight pixel is lost. After deassertion, arbitration restarts with pointer=0.
- Inputs of non-owners may change freely. Only the owner's slice is sampled, and only on ack cycles.

Test Plan:
- Reset idle: resetn=1 then 0 with req=0 for 10 cycles -> gnt=0, vga_plot=0, busy=0, vga_x=vga_y=0 throughout.
- Single burst latency: req[2]=1 at t with px_x=5, px_y=7, colour=3'b110, last=1 -> gnt=4'b0100 at t+1, ack[2]=1 at t+1, vga_plot=1 with x=5, y=7, colour=6 at t+2, gnt=0 at t+2.
- Round-robin: req=4'b1111 held, every pixel last=1 -> owners granted in order 0,1,2,3,0, one IDLE cycle between each, vga_plot pattern 1,0 repeating.
- Forced release: MAX_BURST=4, req[0] and req[1] held, last=0 -> exactly 4 acks to requester 0 (vga_plot high 4 cycles), then gnt=4'b0010.
- Owner stall: requester 1 owns, drops req for one cycle mid-burst -> gnt cleared next edge, vga_plot=0, pointer=2; with req=4'b0011 the next grant goes to requester 0.
- Async reset mid-burst: assert resetn between clock edges during a burst of pixel x=100 -> gnt, vga_plot and busy go to 0 immediately without a clock edge; after release, req[3]=1 is granted within 1 cycle.
